// File: rtl/d_mem_arbiter_if.sv
// d_mem_arbiter_if: req/dir/addr/wdata -> ack/rdata memory handshake bundle
interface d_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          dir;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  modport master (output req, dir, addr, wdata, input ack, rdata);
  modport slave  (input req, dir, addr, wdata, output ack, rdata);
endinterface

// File: rtl/d_mem_arbiter.sv
// d_mem_arbiter: shares one data-memory port between A and B, round-robin or fixed A-priority with DMEM_ARB_FIXED_PRIO_EN
module d_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  d_mem_arbiter_if.slave  a_bus,
  d_mem_arbiter_if.slave  b_bus,
  d_mem_arbiter_if.master m_bus,
  output logic            grant_b_o
);
  localparam logic DIR_READ = 1'b0;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state_q, state_d;
  logic          m_req_q, m_req_d, m_dir_q, m_dir_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d, grant_b_q, grant_b_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          start, fire, pick_b;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic          last_b_q, last_b_d;
`endif
  // winner selection, next-state and registered-output computation
  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    pick_b    = b_bus.req & ~a_bus.req;
`else
    pick_b    = b_bus.req & (~a_bus.req | ~last_b_q);
    last_b_d  = start_sel(pick_b, last_b_q);
`endif
    start     = state_q == IDLE && (a_bus.req || b_bus.req);
    fire      = state_q == BUSY && m_bus.ack;
    state_d   = start ? BUSY : fire ? DONE : state_q == DONE ? IDLE : state_q;
    m_req_d   = start | (m_req_q & ~fire);
    m_dir_d   = start ? (pick_b ? b_bus.dir : a_bus.dir) : m_dir_q;
    m_addr_d  = start ? (pick_b ? b_bus.addr : a_bus.addr) : m_addr_q;
    m_wdata_d = start ? (pick_b ? b_bus.wdata : a_bus.wdata) : m_wdata_q;
    grant_b_d = start ? pick_b : grant_b_q;
    a_ack_d   = fire & ~grant_b_q;
    b_ack_d   = fire & grant_b_q;
    a_rdata_d = a_ack_d && m_dir_q == DIR_READ ? m_bus.rdata : a_rdata_q;
    b_rdata_d = b_ack_d && m_dir_q == DIR_READ ? m_bus.rdata : b_rdata_q;
  end
  function automatic logic start_sel(input logic nv, input logic ov);
    return (state_q == IDLE && (a_bus.req || b_bus.req)) ? nv : ov;
  endfunction
  // state and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_dir_q   <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      grant_b_q <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_b_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_dir_q   <= m_dir_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      grant_b_q <= grant_b_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_b_q  <= last_b_d;
`endif
    end
  end
  assign m_bus.req   = m_req_q;
  assign m_bus.dir   = m_dir_q;
  assign m_bus.addr  = m_addr_q;
  assign m_bus.wdata = m_wdata_q;
  assign a_bus.ack   = a_ack_q;
  assign a_bus.rdata = a_rdata_q;
  assign b_bus.ack   = b_ack_q;
  assign b_bus.rdata = b_rdata_q;
  assign grant_b_o   = grant_b_q;
endmodule

// File: tb/tb_d_mem_arbiter.sv
// tb_d_mem_arbiter: vector table, directed corner sequences and randomized transaction-level model for d_mem_arbiter
module tb_d_mem_arbiter;
  localparam int AW = 8, DW = 8;
  localparam logic RD = 1'b0, WR = 1'b1;
  logic clk = 1'b0, rst_n = 1'b0, grant_b;
  always #5 clk = ~clk;
  d_mem_arbiter_if #(.AW(AW), .DW(DW)) a_bus ();
  d_mem_arbiter_if #(.AW(AW), .DW(DW)) b_bus ();
  d_mem_arbiter_if #(.AW(AW), .DW(DW)) m_bus ();
  d_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .a_bus(a_bus), .b_bus(b_bus), .m_bus(m_bus), .grant_b_o(grant_b)
  );
  int checks = 0, errors = 0, lat = 1, mcnt = 0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  typedef struct {
    logic       is_b;
    logic       dir;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;
  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a == 8'h10 ? 8'h5A : 8'(a * 8'd7 + 8'd3);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic is_b, input logic req, input logic dir, input logic [7:0] addr, input logic [7:0] wdata);
    if (is_b) begin
      b_bus.req = req; b_bus.dir = dir; b_bus.addr = addr; b_bus.wdata = wdata;
    end else begin
      a_bus.req = req; a_bus.dir = dir; a_bus.addr = addr; a_bus.wdata = wdata;
    end
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wait_ack(input logic is_b, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_b ? b_bus.ack : a_bus.ack) && n < 30);
    chk(name, {31'b0, is_b ? b_bus.ack : a_bus.ack}, 1);
  endtask
  // memory: acks lat cycles after it first sees m_req, one-cycle pulse
  initial begin
    m_bus.ack = 1'b0;
    m_bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (m_bus.ack) m_bus.ack = 1'b0;
      else if (m_bus.req) begin
        mcnt++;
        if (mcnt == lat + 1) begin
          mcnt = 0;
          m_bus.ack = 1'b1;
          if (m_bus.dir == RD) m_bus.rdata = mem[m_bus.addr];
          else begin
            mem[m_bus.addr] = m_bus.wdata;
            m_bus.rdata = 8'($urandom);
          end
        end
      end else mcnt = 0;
    end
  end
  initial begin
    vec_t vecs [8];
    int ta, tb, ack_at, gcyc;
    logic exp_b, pa, pb, ga, gb, busy, wb, wdir, gbm, ea, eb, em, drain;
    logic [7:0] waddr, wwd, wrd, ra, rb;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic last_bm;
`endif
    vecs[0] = '{1'b0, RD, 8'h10, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, WR, 8'h20, 8'hC3, 8'h00};
    vecs[2] = '{1'b1, RD, 8'h20, 8'h44, 8'hC3};
    vecs[3] = '{1'b0, WR, 8'h10, 8'h11, 8'h5A};
    vecs[4] = '{1'b0, RD, 8'h10, 8'h00, 8'h11};
    vecs[5] = '{1'b1, WR, 8'hFF, 8'h00, 8'hC3};
    vecs[6] = '{1'b1, RD, 8'hFF, 8'hAA, 8'h00};
    vecs[7] = '{1'b0, RD, 8'h00, 8'h00, 8'h03};
    for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    chk("rst_a_ack", {31'b0, a_bus.ack}, 0);
    chk("rst_b_ack", {31'b0, b_bus.ack}, 0);
    chk("rst_a_rdata", {24'b0, a_bus.rdata}, 0);
    chk("rst_b_rdata", {24'b0, b_bus.rdata}, 0);
    chk("rst_m_req", {31'b0, m_bus.req}, 0);
    chk("rst_m_dir", {31'b0, m_bus.dir}, 0);
    chk("rst_m_addr", {24'b0, m_bus.addr}, 0);
    chk("rst_m_wdata", {24'b0, m_bus.wdata}, 0);
    chk("rst_grant_b", {31'b0, grant_b}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].is_b, 1'b1, vecs[i].dir, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk($sformatf("vec%0d_m_req", i), {31'b0, m_bus.req}, 1);
      chk($sformatf("vec%0d_m_dir", i), {31'b0, m_bus.dir}, {31'b0, vecs[i].dir});
      chk($sformatf("vec%0d_m_addr", i), {24'b0, m_bus.addr}, {24'b0, vecs[i].addr});
      chk($sformatf("vec%0d_m_wdata", i), {24'b0, m_bus.wdata}, {24'b0, vecs[i].wdata});
      chk($sformatf("vec%0d_grant_b", i), {31'b0, grant_b}, {31'b0, vecs[i].is_b});
      @(negedge clk);
      chk($sformatf("vec%0d_early_ack", i), {31'b0, a_bus.ack | b_bus.ack}, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_a_ack", i), {31'b0, a_bus.ack}, {31'b0, ~vecs[i].is_b});
      chk($sformatf("vec%0d_b_ack", i), {31'b0, b_bus.ack}, {31'b0, vecs[i].is_b});
      chk($sformatf("vec%0d_rdata", i), {24'b0, vecs[i].is_b ? b_bus.rdata : a_bus.rdata}, {24'b0, vecs[i].exp_rdata});
      drive(vecs[i].is_b, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk($sformatf("vec%0d_ack_len", i), {31'b0, a_bus.ack | b_bus.ack}, 0);
      chk($sformatf("vec%0d_m_req_off", i), {31'b0, m_bus.req}, 0);
    end
    pulse_reset();
    drive(1'b0, 1'b1, RD, 8'h01, 8'h00);
    drive(1'b1, 1'b1, RD, 8'h02, 8'h00);
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(a_bus.ack | b_bus.ack) && n < 20);
      chk($sformatf("cont%0d_any_ack", k), {31'b0, a_bus.ack | b_bus.ack}, 1);
      chk($sformatf("cont%0d_two_acks", k), {31'b0, a_bus.ack & b_bus.ack}, 0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_b = 1'b0;
`else
      exp_b = 1'(k % 2);
`endif
      chk($sformatf("cont%0d_order", k), {31'b0, b_bus.ack}, {31'b0, exp_b});
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    lat = 5;
    ta = 0;
    drive(1'b0, 1'b1, RD, 8'h40, 8'h00);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 2) drive(1'b0, 1'b1, WR, 8'h99, 8'hEE);
      if (a_bus.ack) begin
        ta = i;
        break;
      end
      chk($sformatf("slow_m_req_c%0d", i), {31'b0, m_bus.req}, {31'b0, i <= 6});
      if (i <= 6) begin
        chk($sformatf("slow_m_addr_c%0d", i), {24'b0, m_bus.addr}, 32'h40);
        chk($sformatf("slow_m_dir_c%0d", i), {31'b0, m_bus.dir}, {31'b0, RD});
      end
    end
    chk("slow_ack_cycle", ta, 7);
    chk("slow_a_rdata", {24'b0, a_bus.rdata}, {24'b0, init_val(8'h40)});
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    lat = 3;
    drive(1'b0, 1'b1, RD, 8'h30, 8'h00);
    @(negedge clk);
    chk("rstbusy_m_req_before", {31'b0, m_bus.req}, 1);
    drive(1'b1, 1'b1, RD, 8'h31, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstbusy_m_req", {31'b0, m_bus.req}, 0);
    chk("rstbusy_no_ack", {31'b0, a_bus.ack | b_bus.ack}, 0);
    chk("rstbusy_grant_b", {31'b0, grant_b}, 0);
    chk("rstbusy_a_rdata", {24'b0, a_bus.rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstbusy_regrant", {31'b0, m_bus.req}, 1);
    chk("rstbusy_tie_addr", {24'b0, m_bus.addr}, 32'h30);
    chk("rstbusy_tie_grant_b", {31'b0, grant_b}, 0);
    wait_ack(1'b0, "rstbusy_a_ack");
    chk("rstbusy_a_rdata_after", {24'b0, a_bus.rdata}, {24'b0, init_val(8'h30)});
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_ack(1'b1, "rstbusy_b_ack");
    chk("rstbusy_b_rdata", {24'b0, b_bus.rdata}, {24'b0, init_val(8'h31)});
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    lat = 1;
    ta = 0;
    tb = 0;
    drive(1'b0, 1'b1, WR, 8'h50, 8'h77);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      chk($sformatf("late_b_two_acks_c%0d", i), {31'b0, a_bus.ack & b_bus.ack}, 0);
      if (a_bus.ack) begin
        ta = i;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      if (b_bus.ack) begin
        tb = i;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      if (i == 2) drive(1'b1, 1'b1, RD, 8'h50, 8'h00);
    end
    chk("late_b_a_ack_cycle", ta, 3);
    chk("late_b_b_ack_cycle", tb, 7);
    chk("late_b_b_rdata", {24'b0, b_bus.rdata}, 32'h77);
    for (int seg = 0; seg < 3; seg++) begin
      lat = seg == 0 ? 1 : seg == 1 ? 2 : 4;
      pulse_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_bm = 1'b1;
`endif
      gbm = 0; ra = 0; rb = 0; busy = 0; pa = 0; pb = 0; ga = 0; gb = 0;
      wb = 0; wdir = 0; waddr = 0; wwd = 0; wrd = 0; gcyc = 0; ack_at = 0;
      for (int t = 0; t < 700; t++) begin
        drain = t >= 400;
        if (busy && t == gcyc + 1) gbm = wb;
        if (busy && t == ack_at && wdir == RD) begin
          if (wb) rb = wrd;
          else ra = wrd;
        end
        if (busy && t > ack_at) busy = 0;
        ea = busy && t == ack_at && !wb;
        eb = busy && t == ack_at && wb;
        em = busy && t > gcyc && t < ack_at;
        chk("rnd_a_ack", {31'b0, a_bus.ack}, {31'b0, ea});
        chk("rnd_b_ack", {31'b0, b_bus.ack}, {31'b0, eb});
        chk("rnd_m_req", {31'b0, m_bus.req}, {31'b0, em});
        chk("rnd_grant_b", {31'b0, grant_b}, {31'b0, gbm});
        chk("rnd_a_rdata", {24'b0, a_bus.rdata}, {24'b0, ra});
        chk("rnd_b_rdata", {24'b0, b_bus.rdata}, {24'b0, rb});
        if (em) begin
          chk("rnd_m_addr", {24'b0, m_bus.addr}, {24'b0, waddr});
          chk("rnd_m_dir", {31'b0, m_bus.dir}, {31'b0, wdir});
          chk("rnd_m_wdata", {24'b0, m_bus.wdata}, {24'b0, wwd});
        end
        if (ea) begin
          pa = 0; ga = 0; a_bus.req = 1'b0;
        end else if (pa && ga) drive(1'b0, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
        else if (!pa && !drain && $urandom_range(0, 2) == 0) begin
          pa = 1;
          drive(1'b0, 1'b1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
        end
        if (eb) begin
          pb = 0; gb = 0; b_bus.req = 1'b0;
        end else if (pb && gb) drive(1'b1, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
        else if (!pb && !drain && $urandom_range(0, 2) == 0) begin
          pb = 1;
          drive(1'b1, 1'b1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
        end
        if (!busy && (pa || pb)) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
          wb = pb && !pa;
`else
          wb = pb && (!pa || !last_bm);
          last_bm = wb;
`endif
          busy = 1;
          gcyc = t;
          ack_at = t + lat + 2;
          wdir = wb ? b_bus.dir : a_bus.dir;
          waddr = wb ? b_bus.addr : a_bus.addr;
          wwd = wb ? b_bus.wdata : a_bus.wdata;
          if (wdir == RD) wrd = ref_mem[waddr];
          else ref_mem[waddr] = wwd;
          if (wb) gb = 1;
          else ga = 1;
        end
        if (drain && !busy && !pa && !pb) break;
        @(negedge clk);
      end
      chk($sformatf("rnd%0d_drained", seg), {29'b0, busy, pa, pb}, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
